register_file_wb: RTL and testbench

Architectural register file for the ARM pipeline. It receives the write-back interface (destination, value, enable) from the write-back stage and serves two combinational read ports to the decode stage. It also keeps a per-register pending-write scoreboard, so decode can detect read-after-write hazards against in-flight EX/MEM/WB writes. A commit counter tracks retired writes.

---
 rtl/register_file_wb_pkg.sv | 30 +++
 rtl/register_file_wb_pending_counter.sv | 40 ++++
 rtl/register_file_wb.sv | 87 ++++++++
 tb/tb_register_file_wb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_wb_pkg.sv
// Shared sizing, types and counter-operation decode for the register_file_wb slice.
package register_file_wb_pkg;

    localparam int unsigned N         = 32;
    localparam int unsigned REG_COUNT = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned COMMIT_W  = 16;

    typedef logic [N-1:0]        word_t;
    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [CNT_W-1:0]    cnt_t;
    typedef logic [COMMIT_W-1:0] commit_t;

    localparam cnt_t CNT_MAX = '1;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

    // An issue and a retire to the same register in one cycle cancel out.
    function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
        if (inc && !dec) return CNT_INC;
        if (dec && !inc) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/register_file_wb_pending_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
module pending_counter
    import register_file_wb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t count_o,
    output logic ovf_o,
    output logic unf_o
);

    cnt_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        unique case (cnt_op(inc_i, dec_i))
            CNT_INC: begin
                if (count_q == CNT_MAX) ovf_o = 1'b1;
                else                    count_d = count_q + 1'b1;
            end
            CNT_DEC: begin
                if (count_q == '0) unf_o = 1'b1;
                else               count_d = count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/register_file_wb.sv
// Architectural register file with write-through read ports, per-register
// pending-write scoreboard for RAW hazard detection, and a retired-write counter.
module register_file_wb
    import register_file_wb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  addr_t   src1,
    input  addr_t   src2,
    input  logic    src2_valid,
    output word_t   reg1_out,
    output word_t   reg2_out,
    input  logic    wb_en_in,
    input  addr_t   wb_dest_in,
    input  word_t   wb_value_in,
    input  logic    issue_en,
    input  addr_t   issue_dest,
    output logic    hazard,
    output commit_t commit_count,
    output logic    overflow_err,
    output logic    underflow_err
);

    word_t regs_q [REG_COUNT];
    cnt_t  cnt    [REG_COUNT];

    logic [REG_COUNT-1:0] inc_vec, dec_vec, ovf_vec, unf_vec;

    commit_t commit_count_q, commit_count_d;
    logic    overflow_err_q, overflow_err_d;
    logic    underflow_err_q, underflow_err_d;

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_cnt
        assign inc_vec[r] = issue_en && (issue_dest == addr_t'(r));
        assign dec_vec[r] = wb_en_in && (wb_dest_in == addr_t'(r));

        pending_counter u_cnt (
            .clk_i   (clk),
            .rst_ni  (rst),
            .inc_i   (inc_vec[r]),
            .dec_i   (dec_vec[r]),
            .count_o (cnt[r]),
            .ovf_o   (ovf_vec[r]),
            .unf_o   (unf_vec[r])
        );
    end

    // dec_vec doubles as the bypass select; the retiring write also lowers the
    // effective pending count, so count > dec is "eff(r) != 0".
    always_comb begin
        reg1_out = dec_vec[src1] ? wb_value_in : regs_q[src1];
        reg2_out = dec_vec[src2] ? wb_value_in : regs_q[src2];
        hazard   = (cnt[src1] > cnt_t'(dec_vec[src1])) ||
                   (src2_valid && (cnt[src2] > cnt_t'(dec_vec[src2])));
    end

    always_comb begin
        commit_count_d  = wb_en_in ? commit_count_q + 1'b1 : commit_count_q;
        overflow_err_d  = overflow_err_q  | (|ovf_vec);
        underflow_err_d = underflow_err_q | (|unf_vec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (wb_en_in) begin
            regs_q[wb_dest_in] <= wb_value_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_count_q  <= '0;
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            commit_count_q  <= commit_count_d;
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign commit_count  = commit_count_q;
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_register_file_wb.sv
// Randomized and directed self-checking bench for register_file_wb against an array-based model.
module tb_register_file_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src1, src2, wb_dest_in, issue_dest;
    logic        src2_valid, wb_en_in, issue_en;
    logic [31:0] wb_value_in;
    logic [31:0] reg1_out, reg2_out;
    logic        hazard, overflow_err, underflow_err;
    logic [15:0] commit_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [16] = '{default: '0};
    int          m_cnt  [16] = '{default: 0};
    int          m_commit = 0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    register_file_wb dut (
        .clk           (clk),
        .rst           (rst),
        .src1          (src1),
        .src2          (src2),
        .src2_valid    (src2_valid),
        .reg1_out      (reg1_out),
        .reg2_out      (reg2_out),
        .wb_en_in      (wb_en_in),
        .wb_dest_in    (wb_dest_in),
        .wb_value_in   (wb_value_in),
        .issue_en      (issue_en),
        .issue_dest    (issue_dest),
        .hazard        (hazard),
        .commit_count  (commit_count),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int s);
        if (wb_en_in && int'(wb_dest_in) == s) return wb_value_in;
        return m_regs[s];
    endfunction

    function automatic bit m_busy(input int s);
        int e;
        e = m_cnt[s] - ((wb_en_in && int'(wb_dest_in) == s) ? 1 : 0);
        return e > 0;
    endfunction

    // Model state update: architectural rules applied to plain integers.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = '0;
                m_cnt[r]  = 0;
            end
            m_commit = 0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                bit inc, dec;
                inc = issue_en && int'(issue_dest) == r;
                dec = wb_en_in && int'(wb_dest_in) == r;
                if (inc && !dec) begin
                    if (m_cnt[r] < 3) m_cnt[r]++;
                    else              m_ovf = 1'b1;
                end else if (dec && !inc) begin
                    if (m_cnt[r] > 0) m_cnt[r]--;
                    else              m_unf = 1'b1;
                end
            end
            if (wb_en_in) begin
                m_regs[wb_dest_in] = wb_value_in;
                m_commit = (m_commit + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_reg1", reg1_out, m_read(int'(src1)));
        chk("m_reg2", reg2_out, m_read(int'(src2)));
        chk("m_hazard", {31'd0, hazard},
            {31'd0, m_busy(int'(src1)) || (src2_valid && m_busy(int'(src2)))});
        chk("m_commit", {16'd0, commit_count}, m_commit);
        chk("m_ovf", {31'd0, overflow_err}, {31'd0, m_ovf});
        chk("m_unf", {31'd0, underflow_err}, {31'd0, m_unf});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en_in   = 1'b0;
        issue_en   = 1'b0;
        src2_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic randomize_inputs(input bit force_wb);
        wb_en_in    = force_wb ? 1'b1 : 1'($urandom_range(0, 1));
        wb_dest_in  = 4'($urandom_range(0, 15));
        wb_value_in = $urandom;
        issue_en    = 1'($urandom_range(0, 1));
        issue_dest  = 4'($urandom_range(0, 3));
        src1        = 4'($urandom_range(0, 15));
        src2        = 4'($urandom_range(0, 15));
        src2_valid  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        idle();
        src1 = '0; src2 = '0; wb_dest_in = '0; issue_dest = '0; wb_value_in = '0;
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            src1 = 4'(i);
            src2 = 4'(15 - i);
            #1;
            chk("rst_reg1", reg1_out, 32'h0);
            chk("rst_reg2", reg2_out, 32'h0);
        end
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        chk("rst_commit", {16'd0, commit_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
        chk("rst_unf", {31'd0, underflow_err}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        tick();

        // Write-through bypass on both ports
        wb_en_in = 1'b1; wb_dest_in = 4'd3; wb_value_in = 32'hDEADBEEF;
        src1 = 4'd3; src2 = 4'd3;
        #1;
        chk("byp_reg1", reg1_out, 32'hDEADBEEF);
        chk("byp_reg2", reg2_out, 32'hDEADBEEF);
        tick();
        wb_en_in = 1'b0;
        #1;
        chk("stored_reg1", reg1_out, 32'hDEADBEEF);
        chk("stored_commit", {16'd0, commit_count}, 32'd1);
        chk("byp_unf", {31'd0, underflow_err}, 32'd1);
        idle();
        pulse_reset();
        tick();

        // RAW hazard on R5
        issue_en = 1'b1; issue_dest = 4'd5; src1 = 4'd5; src2_valid = 1'b0;
        #1 chk("raw_same_cycle", {31'd0, hazard}, 32'd0);
        tick();
        issue_en = 1'b0;
        #1 chk("raw_h1", {31'd0, hazard}, 32'd1);
        tick();
        #1 chk("raw_h2", {31'd0, hazard}, 32'd1);
        wb_en_in = 1'b1; wb_dest_in = 4'd5; wb_value_in = 32'h12345678;
        #1;
        chk("raw_retire_hazard", {31'd0, hazard}, 32'd0);
        chk("raw_retire_bypass", reg1_out, 32'h12345678);
        tick();
        wb_en_in = 1'b0;
        #1;
        chk("raw_after", {31'd0, hazard}, 32'd0);
        chk("raw_unf", {31'd0, underflow_err}, 32'd0);
        chk("raw_stored", reg1_out, 32'h12345678);

        // Saturation and underflow on R2
        src1 = 4'd2; issue_en = 1'b1; issue_dest = 4'd2;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                #1 chk("sat_ovf_before", {31'd0, overflow_err}, 32'd0);
            end
        end
        issue_en = 1'b0;
        #1;
        chk("sat_ovf", {31'd0, overflow_err}, 32'd1);
        chk("sat_hazard", {31'd0, hazard}, 32'd1);
        wb_en_in = 1'b1; wb_dest_in = 4'd2;
        for (int k = 1; k <= 3; k++) begin
            wb_value_in = $urandom;
            #1 chk("sat_retire_hazard", {31'd0, hazard}, (k < 3) ? 32'd1 : 32'd0);
            tick();
        end
        #1 chk("sat_unf_before", {31'd0, underflow_err}, 32'd0);
        tick();
        wb_en_in = 1'b0;
        #1;
        chk("sat_unf", {31'd0, underflow_err}, 32'd1);
        chk("sat_idle_hazard", {31'd0, hazard}, 32'd0);
        idle();
        pulse_reset();
        tick();

        // Simultaneous issue and retire on R7
        issue_en = 1'b1; issue_dest = 4'd7;
        tick();
        wb_en_in = 1'b1; wb_dest_in = 4'd7; wb_value_in = 32'hCAFE0007; src1 = 4'd7;
        #1 chk("sim_hazard", {31'd0, hazard}, 32'd0);
        tick();
        idle();
        #1 chk("sim_next", {31'd0, hazard}, 32'd1);
        src1 = 4'd0; src2 = 4'd7; src2_valid = 1'b0;
        #1 chk("sim_src2_masked", {31'd0, hazard}, 32'd0);
        src2_valid = 1'b1;
        #1 chk("sim_src2_valid", {31'd0, hazard}, 32'd1);
        tick();
        idle();
        pulse_reset();
        tick();

        // Commit counter wrap under randomized traffic
        for (int i = 0; i < 65535; i++) begin
            randomize_inputs(1'b1);
            tick();
        end
        #1 chk("wrap_ffff", {16'd0, commit_count}, 32'h0000FFFF);
        wb_en_in = 1'b1;
        tick();
        wb_en_in = 1'b0;
        #1 chk("wrap_zero", {16'd0, commit_count}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            randomize_inputs(1'b0);
            tick();
        end

        // Asynchronous reset between clock edges
        idle();
        wb_en_in = 1'b1; wb_dest_in = 4'd4; wb_value_in = 32'hA5A5A5A5;
        issue_en = 1'b1; issue_dest = 4'd9;
        tick();
        idle();
        src1 = 4'd9; src2 = 4'd4; src2_valid = 1'b1;
        #1;
        chk("pre_rst_hazard", {31'd0, hazard}, 32'd1);
        chk("pre_rst_reg2", reg2_out, 32'hA5A5A5A5);
        rst = 1'b0;
        #1;
        chk("arst_hazard", {31'd0, hazard}, 32'd0);
        chk("arst_reg1", reg1_out, 32'h0);
        chk("arst_reg2", reg2_out, 32'h0);
        chk("arst_commit", {16'd0, commit_count}, 32'd0);
        chk("arst_ovf", {31'd0, overflow_err}, 32'd0);
        chk("arst_unf", {31'd0, underflow_err}, 32'd0);
        #1 rst = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
